// File: rtl/toggle_event_rx_if.sv
// Event-side bundle of toggle_event_rx: toggle input, consumer handshake and status outputs.
// master = consumer/driver of tog_in, slave = the receiver.
interface toggle_event_rx_if #(
  parameter int CNT_W = 16
);
  logic             tog_in;
  logic             ack;
  logic             clr;
  logic             evt_pulse;
  logic             evt_valid;
  logic [CNT_W-1:0] evt_cnt;
  logic             overflow;
  logic             stall;

  modport master (
    output tog_in, ack, clr,
    input  evt_pulse, evt_valid, evt_cnt, overflow, stall
  );

  modport slave (
    input  tog_in, ack, clr,
    output evt_pulse, evt_valid, evt_cnt, overflow, stall
  );
endinterface

// File: rtl/toggle_event_rx.sv
// Toggle-link receiver: synchronise tog_in, turn each level change into pulse, pending event and count.
// Optional idle-stall detector enabled by defining TOG_RX_TIMEOUT_EN.
//
// state  | meaning
// ST_ARM | settling after reset; prev follows the synchronised level, no events
// ST_RUN | every level change of the synchronised input is an event
module toggle_event_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int PEND_W      = 3,
  parameter int TIMEOUT     = 1024
) (
  input  logic               clk,
  input  logic               reset,
  toggle_event_rx_if.slave   bus
);

  typedef enum logic {ST_ARM, ST_RUN} state_t;

  localparam int ARM_W = $clog2(SYNC_STAGES + 1);

  state_t             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [ARM_W-1:0]   arm_q, arm_d;
  logic               prev_q, prev_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pulse_q, pulse_d;
  logic               ovf_q, ovf_d;

  logic sync_out, detect, take, full, ovf_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.tog_in};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign detect   = (state_q == ST_RUN) && (sync_out ^ prev_q);
  assign take     = bus.ack && (pend_q != '0);
  assign full     = &pend_q;

  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    prev_d  = sync_out;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    pulse_d = detect;
    ovf_d   = ovf_q;
    ovf_set = 1'b0;

    case (state_q)
      ST_ARM: begin
        if (arm_q == '0) state_d = ST_RUN;
        else             arm_d   = arm_q - 1'b1;
      end
      ST_RUN: ;
      default: state_d = ST_ARM;
    endcase

    // a simultaneous detect and accepted ack cancel out
    if (detect && !take) begin
      if (full) ovf_set = 1'b1;
      else      pend_d  = pend_q + 1'b1;
    end else if (!detect && take) begin
      pend_d = pend_q - 1'b1;
    end

    if (bus.clr)     cnt_d = detect ? CNT_W'(1) : '0;
    else if (detect) cnt_d = cnt_q + 1'b1;

    if (ovf_set)      ovf_d = 1'b1;
    else if (bus.clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ARM;
      arm_q   <= ARM_W'(SYNC_STAGES);
      prev_q  <= 1'b0;
      pend_q  <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.evt_pulse = pulse_q;
  assign bus.evt_valid = (pend_q != '0);
  assign bus.evt_cnt   = cnt_q;
  assign bus.overflow  = ovf_q;

`ifdef TOG_RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              stall_q, stall_d;

  // saturating idle counter; stall rises on the edge that completes TIMEOUT quiet cycles
  always_comb begin
    idle_d  = idle_q;
    stall_d = stall_q;
    if (state_q == ST_RUN) begin
      if (detect) begin
        idle_d  = '0;
        stall_d = 1'b0;
      end else begin
        if (idle_q != IDLE_W'(TIMEOUT)) idle_d = idle_q + 1'b1;
        stall_d = stall_q | (idle_q >= IDLE_W'(TIMEOUT - 1));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      stall_q <= stall_d;
    end
  end

  assign bus.stall = stall_q;
`else
  assign bus.stall = 1'b0;
`endif

endmodule
